bp_be_dcache_reservation: RTL and testbench

LR/SC reservation tracker for the BlackParrot D$. Sits directly downstream of the D$ opcode decoder: it consumes the decoded `lr_op`/`sc_op` flags of a committing request, together with its physical address, and returns the store-conditional outcome in the same cycle. It owns a short post-LR lock window that stalls coherence snoops to the reserved block, which guarantees LR/SC forward progress. It also clears the reservation on any accepted snoop to that block.

---
 rtl/bp_be_dcache_reservation.sv | 120 ++++++++++++
 tb/tb_bp_be_dcache_reservation.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bp_be_dcache_reservation.sv
// LR/SC reservation tracker for the D$.
// Tracks one block-granular reservation set by a committing LR and consumed by
// a committing SC. A fresh reservation enters a short LOCKED window during
// which snoops to the reserved block are stalled, guaranteeing LR/SC forward
// progress; afterwards an accepted matching snoop clears the reservation.
//
// Ports:
//   clk_i, reset_i         clock, synchronous active-high reset
//   v_i, lr_i, sc_i        committing request valid and its decoded LR/SC flags
//   paddr_i                physical address of the committing request
//   snoop_v_i              coherence invalidate/evict pending
//   snoop_paddr_i          snoop address
//   snoop_yumi_o           snoop accepted this cycle (combinational)
//   sc_success_o           SC outcome, meaningful with v_i & sc_i (combinational)
//   reserved_o             reservation held (LOCKED or RESERVED), registered
//   locked_o               reservation in its lock window, registered
module bp_be_dcache_reservation #(
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned block_width_p = 512,
    parameter int unsigned lock_cycles_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic                     lr_i,
    input  logic                     sc_i,
    input  logic [paddr_width_p-1:0] paddr_i,
    input  logic                     snoop_v_i,
    input  logic [paddr_width_p-1:0] snoop_paddr_i,
    output logic                     snoop_yumi_o,
    output logic                     sc_success_o,
    output logic                     reserved_o,
    output logic                     locked_o
);

    localparam int unsigned offset_w  = $clog2(block_width_p / 8);
    localparam int unsigned tag_w     = paddr_width_p - offset_w;
    // Keep the counter at least one bit wide so a lock-free build still elaborates.
    localparam int unsigned cnt_w     = (lock_cycles_p > 0) ? $clog2(lock_cycles_p + 1) : 1;
    localparam int unsigned lock_init = (lock_cycles_p > 0) ? lock_cycles_p - 1 : 0;

    typedef enum logic [1:0] {
        e_none     = 2'd0,
        e_locked   = 2'd1,
        e_reserved = 2'd2
    } state_e;

    state_e             state_r, state_n;
    logic [tag_w-1:0]   tag_r, tag_n;
    logic [cnt_w-1:0]   cnt_r, cnt_n;

    logic [tag_w-1:0]   req_tag;
    logic [tag_w-1:0]   snp_tag;
    logic               req_match;
    logic               snp_match;

    // Block-offset bits play no part in the reservation granule.
    logic               unused_offsets;

    assign req_tag        = paddr_i[paddr_width_p-1:offset_w];
    assign snp_tag        = snoop_paddr_i[paddr_width_p-1:offset_w];
    assign unused_offsets = ^{paddr_i[offset_w-1:0], snoop_paddr_i[offset_w-1:0]};

    assign req_match = (req_tag == tag_r);
    assign snp_match = (snp_tag == tag_r);

    // Snoops to the locked block stall; everything else is accepted at once.
    assign snoop_yumi_o = snoop_v_i & ~reset_i
                        & ~((state_r == e_locked) & snp_match);

    // An accepted matching snoop in the same cycle beats the SC.
    assign sc_success_o = v_i & sc_i & ~reset_i
                        & (state_r != e_none) & req_match
                        & ~((state_r == e_reserved) & snoop_yumi_o & snp_match);

    // Next-state: LR > SC > lock countdown > snoop invalidation > hold.
    always_comb begin
        state_n = state_r;
        tag_n   = tag_r;
        cnt_n   = cnt_r;

        if (v_i & lr_i) begin
            tag_n = req_tag;
            if (lock_cycles_p > 0) begin
                state_n = e_locked;
                cnt_n   = cnt_w'(lock_init);
            end else begin
                state_n = e_reserved;
            end
        end else if (v_i & sc_i) begin
            state_n = e_none;
        end else if (state_r == e_locked) begin
            if (cnt_r == '0) begin
                state_n = e_reserved;
            end else begin
                cnt_n = cnt_r - cnt_w'(1);
            end
        end else if ((state_r == e_reserved) & snoop_yumi_o & snp_match) begin
            state_n = e_none;
        end
    end

    // State, tag, counter and registered state decodes.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_none;
            tag_r      <= '0;
            cnt_r      <= '0;
            reserved_o <= 1'b0;
            locked_o   <= 1'b0;
        end else begin
            state_r    <= state_n;
            tag_r      <= tag_n;
            cnt_r      <= cnt_n;
            reserved_o <= (state_n != e_none);
            locked_o   <= (state_n == e_locked);
        end
    end

endmodule

// File: tb/tb_bp_be_dcache_reservation.sv
module tb_bp_be_dcache_reservation;

    localparam int unsigned PW = 40;

    localparam logic [PW-1:0] A      = 40'h00_8000_0040;
    localparam logic [PW-1:0] A78    = 40'h00_8000_0078;
    localparam logic [PW-1:0] A60    = 40'h00_8000_0060;
    localparam logic [PW-1:0] A00    = 40'h00_8000_0000;
    localparam logic [PW-1:0] FAR    = 40'h00_8000_1000;
    localparam logic [PW-1:0] B100   = 40'h00_0000_0100;
    localparam logic [PW-1:0] B200   = 40'h00_0000_0200;
    localparam logic [PW-1:0] Z      = '0;

    logic          clk = 1'b0;
    logic          reset, v, lr, sc, snoop_v;
    logic [PW-1:0] paddr, snoop_paddr;

    logic yumi16, scs16, rsv16, lck16;
    logic yumi0, scs0, rsv0, lck0;

    typedef struct {
        string tag;
        logic  yumi;
        logic  scs;
        logic  rsv;
        logic  lck;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    bp_be_dcache_reservation #(
        .paddr_width_p(PW), .block_width_p(512), .lock_cycles_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v), .lr_i(lr), .sc_i(sc),
        .paddr_i(paddr), .snoop_v_i(snoop_v), .snoop_paddr_i(snoop_paddr),
        .snoop_yumi_o(yumi16), .sc_success_o(scs16),
        .reserved_o(rsv16), .locked_o(lck16)
    );

    bp_be_dcache_reservation #(
        .paddr_width_p(PW), .block_width_p(512), .lock_cycles_p(0)
    ) dut0 (
        .clk_i(clk), .reset_i(reset), .v_i(v), .lr_i(lr), .sc_i(sc),
        .paddr_i(paddr), .snoop_v_i(snoop_v), .snoop_paddr_i(snoop_paddr),
        .snoop_yumi_o(yumi0), .sc_success_o(scs0),
        .reserved_o(rsv0), .locked_o(lck0)
    );

    always #5 clk = ~clk;

    // LR and SC together on a committing request is illegal stimulus.
    always @(posedge clk) begin
        if (!reset) begin
            assert (!(v && lr && sc)) else begin
                errors++;
                $error("FAIL illegal_lr_sc observed v=%b lr=%b sc=%b required not all set", v, lr, sc);
            end
        end
    end

    task automatic check(input string tag, input string what, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%b expected=%b", tag, what, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare mid-cycle.
    task automatic step(input string tag, input bit d0,
                        input logic r, input logic vv, input logic l, input logic s,
                        input logic [PW-1:0] pa,
                        input logic sv, input logic [PW-1:0] spa,
                        input logic ey, input logic es, input logic er, input logic el);
        exp_t e;
        exp_t got;
        reset       = r;
        v           = vv;
        lr          = l;
        sc          = s;
        paddr       = pa;
        snoop_v     = sv;
        snoop_paddr = spa;
        e.tag  = tag;
        e.yumi = ey;
        e.scs  = es;
        e.rsv  = er;
        e.lck  = el;
        q.push_back(e);
        @(negedge clk);
        got = q.pop_front();
        if (d0) begin
            check(got.tag, "yumi",     yumi0, got.yumi);
            check(got.tag, "sc",       scs0,  got.scs);
            check(got.tag, "reserved", rsv0,  got.rsv);
            check(got.tag, "locked",   lck0,  got.lck);
        end else begin
            check(got.tag, "yumi",     yumi16, got.yumi);
            check(got.tag, "sc",       scs16,  got.scs);
            check(got.tag, "reserved", rsv16,  got.rsv);
            check(got.tag, "locked",   lck16,  got.lck);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input bit d0, input int n, input logic er, input logic el);
        for (int i = 0; i < n; i++)
            step(tag, d0, 0, 0, 0, 0, Z, 0, Z, 0, 0, er, el);
    endtask

    initial begin
        reset = 1'b1; v = 1'b0; lr = 1'b0; sc = 1'b0; snoop_v = 1'b0;
        paddr = Z; snoop_paddr = Z;
        @(posedge clk);
        #1;

        // Reset: outputs gated, state cleared on both builds.
        step("rst",    0, 1, 1, 0, 1, A, 1, A, 0, 0, 0, 0);
        step("rst_d0", 1, 1, 1, 0, 1, A, 1, A, 0, 0, 0, 0);

        // Basic pair: LR then SC five cycles later in the same block.
        step("bp_lr",    0, 0, 1, 1, 0, A,   0, Z, 0, 0, 0, 0);
        idle("bp_lock",  0, 4, 1, 1);
        step("bp_sc",    0, 0, 1, 0, 1, A78, 0, Z, 0, 1, 1, 1);
        step("bp_after", 0, 0, 0, 0, 0, Z,   0, Z, 0, 0, 0, 0);

        // Lock stall: matching snoop held through the whole window.
        step("ls_lr", 0, 0, 1, 1, 0, A, 0, Z, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            step("ls_stall", 0, 0, 0, 0, 0, Z, 1, A60, 0, 0, 1, 1);
        step("ls_accept", 0, 0, 0, 0, 0, Z, 1, A60, 1, 0, 1, 0);
        step("ls_none",   0, 0, 0, 0, 0, Z, 1, A60, 1, 0, 0, 0);
        step("ls_sc",     0, 0, 1, 0, 1, A,  0, Z,  0, 0, 0, 0);

        // Non-matching snoops (incl. adjacent block) and a plain store leave it intact.
        step("nm_lr",    0, 0, 1, 1, 0, A, 0, Z,   0, 0, 0, 0);
        idle("nm_lock",  0, 1, 1, 1);
        step("nm_far",   0, 0, 0, 0, 0, Z, 1, FAR, 1, 0, 1, 1);
        step("nm_adj",   0, 0, 0, 0, 0, Z, 1, A00, 1, 0, 1, 1);
        step("nm_store", 0, 0, 1, 0, 0, A, 0, Z,   0, 0, 1, 1);
        step("nm_sc",    0, 0, 1, 0, 1, A, 0, Z,   0, 1, 1, 1);
        step("nm_after", 0, 0, 0, 0, 0, Z, 0, Z,   0, 0, 0, 0);

        // Collision: SC and matching snoop in the first RESERVED cycle.
        step("co_lr",    0, 0, 1, 1, 0, A, 0, Z, 0, 0, 0, 0);
        idle("co_lock",  0, 16, 1, 1);
        step("co_both",  0, 0, 1, 0, 1, A, 1, A, 1, 0, 1, 0);
        step("co_after", 0, 0, 0, 0, 0, Z, 0, Z, 0, 0, 0, 0);

        // Re-LR moves the reservation; SC to old block fails.
        step("rl_lr_a",  0, 0, 1, 1, 0, B100, 0, Z, 0, 0, 0, 0);
        step("rl_lr_b",  0, 0, 1, 1, 0, B200, 0, Z, 0, 0, 1, 1);
        step("rl_sc_a",  0, 0, 1, 0, 1, B100, 0, Z, 0, 0, 1, 1);
        step("rl_gone",  0, 0, 0, 0, 0, Z,    0, Z, 0, 0, 0, 0);
        step("rl_lr_b2", 0, 0, 1, 1, 0, B200, 0, Z, 0, 0, 0, 0);
        step("rl_sc_b",  0, 0, 1, 0, 1, B200, 0, Z, 0, 1, 1, 1);
        step("rl_sc_nr", 0, 0, 1, 0, 1, B200, 0, Z, 0, 0, 0, 0);

        // Reset mid-lock drops the reservation at the next edge.
        step("rm_lr",    0, 0, 1, 1, 0, A, 0, Z, 0, 0, 0, 0);
        idle("rm_lock",  0, 2, 1, 1);
        step("rm_rst",   0, 1, 0, 0, 0, Z, 1, A, 0, 0, 1, 1);
        step("rm_snoop", 0, 0, 0, 0, 0, Z, 1, A, 1, 0, 0, 0);

        // Lock-free build: no LOCKED state, matching snoop accepted at once.
        step("l0_rst",   0, 1, 0, 0, 0, Z, 0, Z, 0, 0, 0, 0);
        step("l0_lr",    1, 0, 1, 1, 0, A, 0, Z, 0, 0, 0, 0);
        step("l0_snoop", 1, 0, 0, 0, 0, Z, 1, A, 1, 0, 1, 0);
        step("l0_none",  1, 0, 0, 0, 0, Z, 0, Z, 0, 0, 0, 0);
        step("l0_lr2",   1, 0, 1, 1, 0, A, 0, Z, 0, 0, 0, 0);
        step("l0_sc",    1, 0, 1, 0, 1, A, 0, Z, 0, 1, 1, 0);
        step("l0_after", 1, 0, 0, 0, 0, Z, 0, Z, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
